clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
Time-of-day controller that produces the hour, minute and second values consumed by the display output stage. It contains a free-running second prescaler, BCD time counters, and a button-driven set-mode state machine (mode/increment). It also generates a per-field blank mask so the field being set blinks on the display. It sits between the board buttons and the display output stage.

Parameters:
CLK_DIV, 1000, clk cycles per second; must be ≥4. Use 1000 for simulation, the board frequency for silicon.
CHIME_SECS, 3, length of the top-of-hour chime in seconds; only used with CHIMEs_EN.

Ports:
clk        input   1  system clock
rst_n      input   1  asynchronous active-low reset
btn_mode   input   1  mode button, asynchronous level, active-high
btn_inc    input   1  increment button, asynchronous level, active-high
hour       output  5  hour, plain binary 0..23
minute     output  7  BCD minute: [6:4] tens 0..5, [3:0] units 0..9
second     output  7  BCD second, same encoding as minute
set_mode   output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
field_blank output 3  one-hot blank request {hour,minute,second}
sec_tick   output  1  one-cycle pulse once per second
chime      output  1  top-of-hour chime

Behaviour:
- Reset: clk and rst_n are fixed as above. Reset is asynchronous and active-low.
  - All outputs are 0, time is 00:00:00, state is RUN, prescaler is 0, synchronisers are 0.
- All outputs are registered. hour, minute and second always hold legal values; no illegal BCD is ever output.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - sec_tick is high for one cycle during the cycle in which the count equals CLK_DIV-1.
  - Runs in every state.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a rising-edge detector.
  - The action registers on the 3rd rising clk edge after the button is first sampled high.
  - Holding a button produces exactly one action; no auto-repeat.
- FSM RUN (set_mode=0):
  - On sec_tick, the time increments: second units 9→0 carries into tens.
  - Second 59→00 carries into minute; minute 59→00 carries into hour; hour 23→0.
  - 23:59:59 → 00:00:00 in a single cycle.
  - btn_inc is ignored.
- FSM transitions on a mode edge: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- In any SET state:
  - sec_tick does not advance the time; the time is frozen.
  - An inc edge increments only the selected field, modulo its range (hour 23→0, minute/second 59→00).
  - There is no carry into other fields.
- Leaving SET_SEC for RUN clears the prescaler to 0. The first increment then occurs exactly CLK_DIV cycles later.
- A mode edge and an inc edge in the same cycle: the mode edge wins and the inc edge is discarded.
- field_blank:
  - All zeros in RUN.
  - In a SET state, the selected field's bit is 1 while prescaler ≥ CLK_DIV/2 (integer division), else 0.
  - Bit order is [2]=hour, [1]=minute, [0]=second.
- Reset asserted mid-operation immediately returns everything to the reset values above, including a pending button edge.

Optional Feature:
CHIME_EN:
- Defined:
  - chime asserts on the cycle after a RUN-state increment lands on MM:SS = 00:00, including the midnight wrap.
  - chime stays high for CHIME_SECS sec_ticks, then drops.
  - Entering any SET state clears chime immediately.
  - Reaching 00:00 by set-mode edits never triggers chime.
- Undefined: chime is tied to 0, and no chime logic is synthesised.

Test Plan:
- Reset, then run 3×CLK_DIV cycles → sec_tick pulses every CLK_DIV cycles; second goes 0x01, 0x02, 0x03; hour=0 and minute=0 throughout.
- Set 23:59:58 via set mode, return to RUN, wait two ticks → 23:59:59, then hour=0, minute=0x00, second=0x00 on the same edge.
- From 09:59:59, one tick → 10:00:00 (hour=5'd10, minute=0x00, second=0x00).
- SET_HOUR at 23 with minute=0x45, one inc pulse → hour=0 and minute remains 0x45. In SET_MIN, set_mode=2 and field_blank toggles between 3'b000 and 3'b010 each half second.
- btn_mode and btn_inc rise in the same cycle in SET_HOUR with hour=5 → set_mode becomes 2 and hour stays 5. A 50-cycle held inc gives exactly +1.
- With CHIME_EN and CHIME_SECS=3, run from 00:59:59 → chime high from the cycle after reaching 01:00:00 for 3 ticks. Entering SET_HOUR mid-chime drops chime at once. Without CHIME_EN, chime is constantly 0.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: free-running second prescaler, BCD hh:mm:ss counters and a
// two-button set-mode FSM with blinking field mask. Define CHIME_EN to build the top-of-hour chime.
module clock_time_ctrl #(
    parameter int CLK_DIV    = 1000,
    parameter int CHIME_SECS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [6:0] minute,
    output logic [6:0] second,
    output logic [1:0] set_mode,
    output logic [2:0] field_blank,
    output logic       sec_tick,
    output logic       chime
);

    localparam int            PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_DIV / 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hour_q, hour_d;
    logic [6:0]    min_q, min_d;
    logic [6:0]    sec_q, sec_d;
    logic [2:0]    blank_q, blank_d;
    logic          tick_q, tick_d;
    logic [2:0]    mode_sync_q, inc_sync_q;
    logic          mode_edge, inc_edge;

    // Two-digit BCD increment that wraps 59 -> 00.
    function automatic logic [6:0] bcd60_inc(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[6:4] = (v[6:4] == 3'd5) ? 3'd0 : v[6:4] + 3'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[6:4] = v[6:4];
        end
        return r;
    endfunction

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Bits [1:0] are the synchroniser, bit [2] holds the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
        end else begin
            // NOTE: non-blocking so each flop captures its neighbour's pre-edge value and the chain really shifts.
            mode_sync_q <= {mode_sync_q[1:0], btn_mode};
            inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
        end
    end

    assign mode_edge = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_edge  = inc_sync_q[1] & ~inc_sync_q[2];

    always_comb begin
        if (state_q == SET_SEC && mode_edge) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign tick_d = (presc_d == PRESC_MAX);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;

        if (mode_edge) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                default:  state_d = RUN;
            endcase
        end

        if (state_q == RUN) begin
            if (tick_q) begin
                sec_d = bcd60_inc(sec_q);
                if (sec_q == 7'h59) begin
                    min_d = bcd60_inc(min_q);
                    if (min_q == 7'h59) begin
                        hour_d = hour_inc(hour_q);
                    end
                end
            end
        end else if (inc_edge && !mode_edge) begin
            case (state_q)
                SET_HOUR: hour_d = hour_inc(hour_q);
                SET_MIN:  min_d  = bcd60_inc(min_q);
                default:  sec_d  = bcd60_inc(sec_q);
            endcase
        end
    end

    // Blank mask is computed from next state so the registered copy lines up with set_mode.
    always_comb begin
        blank_d = 3'b000;
        if (presc_d >= PRESC_HALF) begin
            case (state_d)
                SET_HOUR: blank_d = 3'b100;
                SET_MIN:  blank_d = 3'b010;
                SET_SEC:  blank_d = 3'b001;
                default:  blank_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            blank_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CHIME_EN
    localparam int CW = (CHIME_SECS > 0) ? $clog2(CHIME_SECS + 1) : 1;

    logic          top_q, top_d;
    logic          chime_q, chime_d;
    logic [CW-1:0] chime_cnt_q, chime_cnt_d;

    // Only a running rollover onto mm:ss = 00:00 arms the chime; edits in set mode never do.
    assign top_d = (state_q == RUN) && tick_q && (min_d == 7'h00) && (sec_d == 7'h00);

    always_comb begin
        chime_d     = chime_q;
        chime_cnt_d = chime_cnt_q;
        if (state_d != RUN) begin
            chime_d     = 1'b0;
            chime_cnt_d = '0;
        end else if (top_q) begin
            chime_d     = 1'b1;
            chime_cnt_d = CW'(CHIME_SECS);
        end else if (chime_q && tick_q) begin
            if (chime_cnt_q <= CW'(1)) begin
                chime_d     = 1'b0;
                chime_cnt_d = '0;
            end else begin
                chime_cnt_d = chime_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q       <= 1'b0;
            chime_q     <= 1'b0;
            chime_cnt_q <= '0;
        end else begin
            top_q       <= top_d;
            chime_q     <= chime_d;
            chime_cnt_q <= chime_cnt_d;
        end
    end

    assign chime = chime_q;
`else
    localparam int unused_chime_secs = CHIME_SECS;

    assign chime = 1'b0;
`endif

    assign hour        = hour_q;
    assign minute      = min_q;
    assign second      = sec_q;
    assign set_mode    = state_q;
    assign field_blank = blank_q;
    assign sec_tick    = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: a plain-integer time-of-day model checked every
// cycle, plus directed scenarios with literal expectations. Honours CHIME_EN like the RTL.
module tb_clock_time_ctrl;

    localparam int CLK_DIV    = 1000;
    localparam int CHIME_SECS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [4:0] hour;
    logic [6:0] minute;
    logic [6:0] second;
    logic [1:0] set_mode;
    logic [2:0] field_blank;
    logic       sec_tick;
    logic       chime;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    clock_time_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .CHIME_SECS(CHIME_SECS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .set_mode   (set_mode),
        .field_blank(field_blank),
        .sec_tick   (sec_tick),
        .chime      (chime)
    );

    always #5 clk = ~clk;

    // Model state in plain integers: time in binary, mode 0..3, button actions as countdowns.
    typedef struct packed {
        int h;
        int m;
        int s;
        int mode;
        int presc;
        int mode_due;
        int inc_due;
        int chime_left;
        bit mode_prev;
        bit inc_prev;
        bit top;
    } model_t;

    model_t mdl = '0;

    function automatic model_t model_next(input model_t c, input logic bm, input logic bi);
        model_t n;
        bit     tick, fire_mode, fire_inc, run_inc;
        n         = c;
        tick      = (c.presc == CLK_DIV - 1);
        fire_mode = (c.mode_due == 1);
        fire_inc  = (c.inc_due == 1);
        if (n.mode_due > 0) n.mode_due--;
        if (n.inc_due > 0) n.inc_due--;
        // A button first seen high acts two edges after that sample (the third edge overall).
        if (bm && !c.mode_prev) n.mode_due = 2;
        if (bi && !c.inc_prev) n.inc_due = 2;
        n.mode_prev = bm;
        n.inc_prev  = bi;

        run_inc = (c.mode == 0) && tick;
        if (run_inc) begin
            n.s = n.s + 1;
            if (n.s == 60) begin
                n.s = 0;
                n.m = n.m + 1;
                if (n.m == 60) begin
                    n.m = 0;
                    n.h = (n.h + 1) % 24;
                end
            end
        end else if (fire_inc && !fire_mode) begin
            case (c.mode)
                1: n.h = (c.h + 1) % 24;
                2: n.m = (c.m + 1) % 60;
                3: n.s = (c.s + 1) % 60;
                default: ;
            endcase
        end

        n.presc = (c.mode == 3 && fire_mode) ? 0 : (c.presc + 1) % CLK_DIV;
        n.mode  = fire_mode ? (c.mode + 1) % 4 : c.mode;

`ifdef CHIME_EN
        if (n.mode != 0) begin
            n.chime_left = 0;
            n.top        = 1'b0;
        end else begin
            if (c.top) n.chime_left = CHIME_SECS;
            else if (c.chime_left > 0 && tick) n.chime_left = c.chime_left - 1;
            n.top = run_inc && (n.m == 0) && (n.s == 0);
        end
`endif
        return n;
    endfunction

    function automatic logic [6:0] bcd(input int v);
        return {3'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [25:0] model_outputs(input model_t c);
        logic [2:0] blank;
        blank = 3'b000;
        if (c.mode != 0 && c.presc >= CLK_DIV / 2) blank = 3'b100 >> (c.mode - 1);
        return {5'(c.h), bcd(c.m), bcd(c.s), 2'(c.mode), blank,
                (c.presc == CLK_DIV - 1), (c.chime_left > 0)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= model_next(mdl, btn_mode, btn_inc);
    end

    logic [25:0] dut_vec;
    assign dut_vec = {hour, minute, second, set_mode, field_blank, sec_tick, chime};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) check("cycle", 32'(dut_vec), 32'(model_outputs(mdl)));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise a button, return just after the edge on which its action lands, then release it.
    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1;
        else         btn_inc  = 1'b1;
        step(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    // From RUN: walk every field to the target and return right after the edge that re-enters RUN.
    task automatic set_time(input int h, input int m, input int s);
        press(1'b1);
        step(3);
        repeat ((h - mdl.h + 24) % 24) begin
            press(1'b0);
            step(3);
        end
        press(1'b1);
        step(3);
        repeat ((m - mdl.m + 60) % 60) begin
            press(1'b0);
            step(3);
        end
        press(1'b1);
        step(3);
        repeat ((s - mdl.s + 60) % 60) begin
            press(1'b0);
            step(3);
        end
        press(1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        cmp_en = 1'b1;
        step(3);
        check("reset_outputs", 32'(dut_vec), 32'h0);
        rst_n = 1'b1;

        // Free run: one second per CLK_DIV cycles, sec_tick in the last prescaler cycle.
        step(CLK_DIV - 1);
        check("t1_tick_high", 32'(sec_tick), 32'h1);
        check("t1_sec_before", 32'(second), 32'h00);
        step(1);
        check("t1_sec1", 32'(second), 32'h01);
        check("t1_tick_low", 32'(sec_tick), 32'h0);
        step(CLK_DIV);
        check("t1_sec2", 32'(second), 32'h02);
        step(CLK_DIV);
        check("t1_sec3", 32'(second), 32'h03);
        check("t1_hour_min", 32'({hour, minute}), 32'h0);
        press(1'b0);
        check("t1_inc_ignored", 32'({hour, minute, second}), 32'({5'd0, 7'h00, 7'h03}));
        step(3);

        // Midnight rollover, and first tick exactly CLK_DIV cycles after leaving set mode.
        set_time(23, 59, 58);
        check("t2_run", 32'(set_mode), 32'h0);
        step(CLK_DIV - 1);
        check("t2_no_early_inc", 32'(second), 32'h58);
        step(1);
        check("t2_235959", 32'({hour, minute, second}), 32'({5'd23, 7'h59, 7'h59}));
        step(CLK_DIV);
        check("t2_midnight", 32'({hour, minute, second}), 32'({5'd0, 7'h00, 7'h00}));
        step(3);

        set_time(9, 59, 59);
        step(CLK_DIV);
        check("t3_ten_oclock", 32'({hour, minute, second}), 32'({5'd10, 7'h00, 7'h00}));
        step(3);

        // Hour wraps in SET_HOUR without touching the minute.
        set_time(23, 45, 0);
        step(3);
        press(1'b1);
        check("t4_set_hour", 32'(set_mode), 32'h1);
        step(3);
        press(1'b0);
        check("t4_hour_wrap", 32'({hour, minute}), 32'({5'd0, 7'h45}));
        step(3);

        repeat (5) begin
            press(1'b0);
            step(3);
        end
        check("t5_hour5", 32'(hour), 32'd5);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check("t5_mode_wins", 32'({set_mode, hour}), 32'({2'd2, 5'd5}));
        step(3);

        begin : find_tick
            int n;
            n = 0;
            while (sec_tick !== 1'b1 && n < 2 * CLK_DIV) begin
                step(1);
                n++;
            end
            check("t5_tick_seen", 32'(sec_tick), 32'h1);
        end
        check("t5_blank_on", 32'(field_blank), 32'b010);
        step(1);
        check("t5_blank_off", 32'(field_blank), 32'b000);
        step(CLK_DIV / 2 - 1);
        check("t5_blank_still_off", 32'(field_blank), 32'b000);
        step(1);
        check("t5_blank_on_half", 32'(field_blank), 32'b010);

        btn_inc = 1'b1;
        step(50);
        check("t5_held_inc", 32'(minute), 32'h46);
        btn_inc = 1'b0;
        step(3);
        check("t5_held_once", 32'(minute), 32'h46);
        repeat (13) begin
            press(1'b0);
            step(3);
        end
        check("t5_min59", 32'(minute), 32'h59);
        press(1'b0);
        check("t5_min_wrap_no_carry", 32'({hour, minute}), 32'({5'd5, 7'h00}));
        step(3);
        press(1'b1);
        check("t5_set_sec", 32'(set_mode), 32'h3);
        step(3);
        press(1'b1);
        check("t5_back_to_run", 32'({set_mode, field_blank}), 32'h0);
        step(3);

`ifdef CHIME_EN
        set_time(0, 59, 59);
        step(CLK_DIV - 1);
        check("t6_pre_chime", 32'(chime), 32'h0);
        step(1);
        check("t6_top", 32'({hour, minute, second, chime}), 32'({5'd1, 7'h00, 7'h00, 1'b0}));
        step(1);
        check("t6_chime_on", 32'(chime), 32'h1);
        step(3 * CLK_DIV - 2);
        check("t6_chime_last", 32'({sec_tick, chime}), 32'b11);
        step(1);
        check("t6_chime_off", 32'(chime), 32'h0);
        step(3);
        set_time(1, 59, 59);
        step(CLK_DIV + 5);
        check("t6_chime_again", 32'(chime), 32'h1);
        press(1'b1);
        check("t6_set_kills_chime", 32'({set_mode, chime}), 32'({2'd1, 1'b0}));
        step(3);
`else
        set_time(0, 59, 59);
        step(CLK_DIV + 2);
        check("t6_no_chime", 32'({hour, minute, second, chime}), 32'({5'd1, 7'h00, 7'h00, 1'b0}));
        step(3);
`endif

        // Asynchronous reset mid-operation, discarding a button edge already in the synchroniser.
        btn_mode = 1'b1;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_reset", 32'(dut_vec), 32'h0);
        btn_mode = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(6);
        check("t7_no_pending_edge", 32'({set_mode, hour, minute, second}), 32'h0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
